// File: rtl/color_detect_multi_if.sv
// Pixel stream, handshake and result bus of the multi-region colour detector.
// The pixel source is the master; the detector is the slave.
interface color_detect_multi_if #(
  parameter int NUM_REGIONS = 4
);
  logic                     start;
  logic                     frame_start;
  logic                     de;
  logic [9:0]               x_pixel;
  logic [9:0]               y_pixel;
  logic [3:0]               red_port;
  logic [3:0]               green_port;
  logic [3:0]               blue_port;
  logic                     busy;
  logic                     done;
  logic [3*NUM_REGIONS-1:0] detected_color;
  logic [NUM_REGIONS-1:0]   region_valid;

  modport master (
    output start, frame_start, de, x_pixel, y_pixel, red_port, green_port, blue_port,
    input  busy, done, detected_color, region_valid
  );

  modport slave (
    input  start, frame_start, de, x_pixel, y_pixel, red_port, green_port, blue_port,
    output busy, done, detected_color, region_valid
  );
endinterface

// File: rtl/color_detect_multi.sv
// Multi-window colour detector: classifies RGB444 pixels, counts per-region
// colour hits over FRAMES frames and votes one colour code per region.
module color_detect_multi #(
  parameter int         NUM_REGIONS = 4,
  parameter int         ROI_X0      = 64,
  parameter int         ROI_Y0      = 200,
  parameter int         ROI_PITCH   = 128,
  parameter int         ROI_W       = 64,
  parameter int         ROI_H       = 64,
  parameter int         FRAMES      = 4,
  parameter logic [3:0] TH_HI       = 4'd10,
  parameter logic [3:0] TH_LO       = 4'd6,
  parameter int         MIN_PIX     = 256,
  parameter int         CNT_W       = $clog2(ROI_W*ROI_H*FRAMES+1)
) (
  input logic               clk,
  input logic               reset,
  color_detect_multi_if.slave cd
);
  localparam int FC_W = $clog2(FRAMES + 1);
  localparam int RK_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACCUM, S_DECIDE, S_DONE} state_t;

  state_t                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [FC_W-1:0]          frame_cnt_q;
  logic [RK_W-1:0]          k_q;
  logic [3*NUM_REGIONS-1:0] res_q;
  logic [3*NUM_REGIONS-1:0] color_q;
  logic [NUM_REGIONS-1:0]   valid_q;
  logic [NUM_REGIONS-1:0]   res_valid;

  logic [2:0]               cls_d, cls_q;
  logic [NUM_REGIONS-1:0]   hit_d, hit_q;
  logic                     r_hi, g_hi, b_hi, r_lo, g_lo, b_lo;

  logic                     cnt_clr;
  logic                     cnt_en;
  logic [NUM_REGIONS*4*CNT_W-1:0] cnt_flat;

  logic [CNT_W-1:0]         win_cnt;
  logic [CNT_W-1:0]         cand;
  logic [2:0]               win_code;

  genvar gi, gj;

  // Stage 1: pixel classification (1=R, 2=G, 3=B, 4=Y, 0=none)
  always_comb begin
    r_hi  = (cd.red_port   >= TH_HI);
    g_hi  = (cd.green_port >= TH_HI);
    b_hi  = (cd.blue_port  >= TH_HI);
    r_lo  = (cd.red_port   <  TH_LO);
    g_lo  = (cd.green_port <  TH_LO);
    b_lo  = (cd.blue_port  <  TH_LO);
    cls_d = 3'd0;
    if (r_hi && g_hi && b_lo)      cls_d = 3'd4;
    else if (r_hi && g_lo && b_lo) cls_d = 3'd1;
    else if (g_hi && r_lo && b_lo) cls_d = 3'd2;
    else if (b_hi && r_lo && g_lo) cls_d = 3'd3;
  end

  for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
    localparam int XL = ROI_X0 + gi * ROI_PITCH;
    assign hit_d[gi] = cd.de &&
                       (int'(cd.x_pixel) >= XL) && (int'(cd.x_pixel) < XL + ROI_W) &&
                       (int'(cd.y_pixel) >= ROI_Y0) && (int'(cd.y_pixel) < ROI_Y0 + ROI_H);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q <= 3'd0;
      hit_q <= '0;
    end else begin
      cls_q <= cls_d;
      hit_q <= hit_d;
    end
  end

  // Stage 2: saturating counters, index 0..3 = R/G/B/Y
  assign cnt_clr = (state_q == S_IDLE) && cd.start;
  assign cnt_en  = (state_q == S_ACCUM);

  for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    for (gj = 0; gj < 4; gj++) begin : g_colour
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          cnt_q <= '0;
        else if (cnt_clr)
          cnt_q <= '0;
        else if (cnt_en && hit_q[gi] && (cls_q == 3'(gj + 1)) && (cnt_q != {CNT_W{1'b1}}))
          cnt_q <= cnt_q + 1'b1;
      end
      assign cnt_flat[(gi*4+gj)*CNT_W +: CNT_W] = cnt_q;
    end
    assign res_valid[gi] = |res_q[3*gi +: 3];
  end

  // Strictly-greater compare in code order gives ties to the lowest code
  always_comb begin
    win_cnt  = cnt_flat[(int'(k_q)*4)*CNT_W +: CNT_W];
    win_code = 3'd1;
    cand     = '0;
    for (int c = 1; c < 4; c++) begin
      cand = cnt_flat[(int'(k_q)*4 + c)*CNT_W +: CNT_W];
      if (cand > win_cnt) begin
        win_cnt  = cand;
        win_code = 3'(c + 1);
      end
    end
    if (int'(win_cnt) < MIN_PIX)
      win_code = 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      k_q         <= '0;
      res_q       <= '0;
      color_q     <= '0;
      valid_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cd.start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          if (cd.frame_start) begin
            state_q     <= S_ACCUM;
            frame_cnt_q <= '0;
          end
        end
        S_ACCUM: begin
          if (cd.frame_start) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (frame_cnt_q + 1'b1 == FC_W'(FRAMES)) begin
              state_q <= S_DECIDE;
              k_q     <= '0;
            end
          end
        end
        S_DECIDE: begin
          res_q[3*k_q +: 3] <= win_code;
          if (k_q == RK_W'(NUM_REGIONS - 1))
            state_q <= S_DONE;
          else
            k_q <= k_q + 1'b1;
        end
        S_DONE: begin
          // Results are staged in res_q so the outputs change in one step
          color_q <= res_q;
          valid_q <= res_valid;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cd.busy           = busy_q;
  assign cd.done           = done_q;
  assign cd.detected_color = color_q;
  assign cd.region_valid   = valid_q;
endmodule

// File: tb/tb_color_detect_multi.sv
// Scoreboard bench for color_detect_multi: a default-width instance and a
// 4-bit-counter instance share one stimulus stream.
`timescale 1ns/1ps
module tb_color_detect_multi;
  localparam int         NR    = 2;
  localparam int         X0    = 64;
  localparam int         Y0    = 200;
  localparam int         PITCH = 128;
  localparam int         W     = 4;
  localparam int         H     = 4;
  localparam int         FR    = 2;
  localparam int         MINP  = 8;
  localparam logic [3:0] THH   = 4'd10;
  localparam logic [3:0] THL   = 4'd6;
  localparam int         MAX_MAIN = 63;  // 6-bit counters for 4x4x2 windows
  localparam int         MAX_SAT  = 15;  // forced 4-bit counters

  typedef struct {
    int                tid;
    logic [3*NR-1:0]   dc;
    logic [NR-1:0]     rv;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_detect_multi_if #(.NUM_REGIONS(NR)) bus ();
  color_detect_multi_if #(.NUM_REGIONS(NR)) bus_s ();

  assign bus_s.start       = bus.start;
  assign bus_s.frame_start = bus.frame_start;
  assign bus_s.de          = bus.de;
  assign bus_s.x_pixel     = bus.x_pixel;
  assign bus_s.y_pixel     = bus.y_pixel;
  assign bus_s.red_port    = bus.red_port;
  assign bus_s.green_port  = bus.green_port;
  assign bus_s.blue_port   = bus.blue_port;

  color_detect_multi #(.NUM_REGIONS(NR), .ROI_X0(X0), .ROI_Y0(Y0), .ROI_PITCH(PITCH),
                       .ROI_W(W), .ROI_H(H), .FRAMES(FR), .TH_HI(THH), .TH_LO(THL),
                       .MIN_PIX(MINP)) dut (.clk(clk), .reset(reset), .cd(bus));

  color_detect_multi #(.NUM_REGIONS(NR), .ROI_X0(X0), .ROI_Y0(Y0), .ROI_PITCH(PITCH),
                       .ROI_W(W), .ROI_H(H), .FRAMES(FR), .TH_HI(THH), .TH_LO(THL),
                       .MIN_PIX(MINP), .CNT_W(4)) dut_sat (.clk(clk), .reset(reset), .cd(bus_s));

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   mcnt [NR][4];
  bit   counting = 1'b0;
  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t e_m, e_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int classify(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    bit rh, gh, bh, rl, gl, bl;
    rh = r >= THH; gh = g >= THH; bh = b >= THH;
    rl = r < THL;  gl = g < THL;  bl = b < THL;
    if (rh && gh && bl) return 4;
    if (rh && gl && bl) return 1;
    if (gh && rl && bl) return 2;
    if (bh && rl && gl) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] exp_code(input int k, input int maxv);
    int         best, v;
    logic [2:0] code;
    best = (mcnt[k][0] > maxv) ? maxv : mcnt[k][0];
    code = 3'd1;
    for (int c = 1; c < 4; c++) begin
      v = (mcnt[k][c] > maxv) ? maxv : mcnt[k][c];
      if (v > best) begin best = v; code = 3'(c + 1); end
    end
    if (best < MINP) code = 3'd0;
    return code;
  endfunction

  task automatic push_expect(input int tid, input int cyc_exp);
    exp_t em, es;
    em.tid = tid; em.cyc = cyc_exp; es.tid = tid; es.cyc = cyc_exp;
    for (int k = 0; k < NR; k++) begin
      em.dc[3*k +: 3] = exp_code(k, MAX_MAIN);
      em.rv[k]        = (exp_code(k, MAX_MAIN) != 3'd0);
      es.dc[3*k +: 3] = exp_code(k, MAX_SAT);
      es.rv[k]        = (exp_code(k, MAX_SAT) != 3'd0);
    end
    q_main.push_back(em);
    q_sat.push_back(es);
  endtask

  // Scoreboard pops on each done pulse
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      check_eq("main_pending", q_main.size(), 1);
      if (q_main.size() > 0) begin
        e_m = q_main.pop_front();
        check_eq($sformatf("t%0d_color", e_m.tid), bus.detected_color, e_m.dc);
        check_eq($sformatf("t%0d_valid", e_m.tid), bus.region_valid, e_m.rv);
        check_eq($sformatf("t%0d_done_cycle", e_m.tid), cyc, e_m.cyc);
        check_eq($sformatf("t%0d_busy_at_done", e_m.tid), bus.busy, 1'b0);
      end
    end
    if (bus_s.done) begin
      check_eq("sat_pending", q_sat.size(), 1);
      if (q_sat.size() > 0) begin
        e_s = q_sat.pop_front();
        check_eq($sformatf("t%0d_sat_color", e_s.tid), bus_s.detected_color, e_s.dc);
        check_eq($sformatf("t%0d_sat_valid", e_s.tid), bus_s.region_valid, e_s.rv);
      end
    end
  end

  task automatic pix(input int x, input int y, input logic [3:0] r, input logic [3:0] g,
                     input logic [3:0] b, input bit de = 1'b1);
    int c;
    @(negedge clk);
    bus.de = de; bus.x_pixel = 10'(x); bus.y_pixel = 10'(y);
    bus.red_port = r; bus.green_port = g; bus.blue_port = b;
    c = classify(r, g, b);
    if (counting && de && c != 0)
      for (int k = 0; k < NR; k++)
        if (x >= X0 + k*PITCH && x < X0 + k*PITCH + W && y >= Y0 && y < Y0 + H)
          mcnt[k][c-1]++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.de = 1'b0;
    end
  endtask

  task automatic fs(input bit with_start);
    @(negedge clk);
    bus.de = 1'b0; bus.frame_start = 1'b1; bus.start = with_start;
    @(negedge clk);
    bus.frame_start = 1'b0; bus.start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.de = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic frame(input int tst, input int f);
    case (tst)
      1: for (int y = 0; y < H; y++)
           for (int x = 0; x < W; x++) begin
             pix(X0 + x, Y0 + y, 4'hF, 4'h0, 4'h0);
             pix(X0 + PITCH + x, Y0 + y, 4'hF, 4'hF, 4'h0);
           end
      2: begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++)
            if (f == 0) pix(X0 + x, Y0 + y, 4'hF, 4'h0, 4'h0);
            else        pix(X0 + x, Y0 + y, 4'h0, 4'h0, 4'hF);
        if (f == 0)
          for (int i = 0; i < 7; i++) pix(X0 + PITCH + (i % 4), Y0 + i / 4, 4'h0, 4'hF, 4'h0);
      end
      3: begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) pix(X0 + x, Y0 + y, 4'd5, 4'd10, 4'd5);
        if (f == 0) pulse_start();
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) pix(X0 + PITCH + x, Y0 + y, 4'd0, 4'd5, 4'd10);
      end
      4: begin
        for (int y = 0; y < 2; y++) begin
          pix(X0, Y0 + y, 4'hF, 4'h0, 4'h0);
          pix(X0 + W - 1, Y0 + y, 4'hF, 4'h0, 4'h0);
        end
        for (int y = 0; y < H; y++) begin
          pix(X0 - 1, Y0 + y, 4'h0, 4'h0, 4'hF);
          pix(X0 + W, Y0 + y, 4'h0, 4'h0, 4'hF);
          pix(X0 + 1, Y0 + y, 4'h0, 4'h0, 4'hF, 1'b0);
        end
        pix(X0 + 1, Y0 - 1, 4'h0, 4'h0, 4'hF);
        pix(X0 + 1, Y0 + H, 4'h0, 4'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
          pix(X0 + PITCH + 1, Y0 + 1, 4'd9, 4'd0, 4'd0);
          pix(X0 + PITCH + 1, Y0 + 1, 4'hF, 4'd6, 4'd0);
          pix(X0 + PITCH + 1, Y0 + 1, 4'hF, 4'hF, 4'd6);
        end
      end
      default: begin
        repeat (20) pix(X0, Y0, 4'hF, 4'h0, 4'h0);
        repeat (7)  pix(X0 + 1, Y0, 4'h0, 4'hF, 4'h0);
        repeat (6)  pix(X0 + PITCH + 2, Y0 + 3, 4'h0, 4'h0, 4'hF);
      end
    endcase
    idle(3);
  endtask

  task automatic run(input int tst);
    int n0, wait_cnt;
    n0 = n_done;
    for (int k = 0; k < NR; k++)
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
    if (tst == 3) fs(1'b1);
    else pulse_start();
    idle(2);
    check_eq($sformatf("t%0d_busy_armed", tst), bus.busy, 1'b1);
    if (tst == 3) pulse_start();
    fs(1'b0);
    counting = 1'b1;
    for (int f = 0; f < FR; f++) begin
      frame(tst, f);
      if (f == FR - 1) begin
        counting = 1'b0;
        @(negedge clk);
        push_expect(tst, cyc + 1 + NR + 1);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
      end else begin
        fs(1'b0);
      end
    end
    wait_cnt = 0;
    while ((q_main.size() > 0 || q_sat.size() > 0) && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (q_main.size() > 0 || q_sat.size() > 0) begin
      check_eq($sformatf("t%0d_done_timeout", tst), q_main.size() + q_sat.size(), 0);
      q_main.delete();
      q_sat.delete();
    end
    idle(8);
    check_eq($sformatf("t%0d_done_count", tst), n_done - n0, 1);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    bus.start = 1'b0; bus.frame_start = 1'b0; bus.de = 1'b0;
    bus.x_pixel = '0; bus.y_pixel = '0;
    bus.red_port = '0; bus.green_port = '0; bus.blue_port = '0;
    idle(3);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_color", bus.detected_color, '0);
    check_eq("rst_valid", bus.region_valid, '0);
    reset = 1'b0;
    idle(3);

    run(1);

    // Abort mid-ACCUM with an asynchronous reset
    n0 = n_done;
    pulse_start();
    idle(2);
    fs(1'b0);
    counting = 1'b1;
    for (int i = 0; i < 6; i++) pix(X0 + (i % 4), Y0, 4'hF, 4'h0, 4'h0);
    @(negedge clk);
    bus.de = 1'b0;
    check_eq("abort_busy_before", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_color", bus.detected_color, '0);
    check_eq("abort_valid", bus.region_valid, '0);
    check_eq("abort_sat_color", bus_s.detected_color, '0);
    counting = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    check_eq("abort_no_done", n_done, n0);

    run(2);
    run(3);
    run(4);
    run(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
